reg_file_sb: RTL and testbench

- Architectural register file with a write-pending scoreboard for the MIPS datapath.
- Sits directly downstream of the RegDst write-register mux, which supplies its write address WR.
- Provides two combinational read ports, one synchronous write port with write-through bypass, and a busy-bit scoreboard.
- The Stall output holds issue while a source operand still has an outstanding producer.

---
 rtl/reg_file_sb.sv | 101 ++++++++++
 tb/tb_reg_file_sb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: architectural register file with a write-pending scoreboard.
//   Two combinational read ports with same-cycle write-through bypass, one
//   synchronous write port, and a busy-bit scoreboard that raises Stall while
//   a source operand still has an outstanding producer.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   RA1/RA2, RD1/RD2 read addresses (rs/rt) and combinational read data
//   WR, WD, RegWrite write-back address (from RegDst mux), data, enable
//   Issue, IssueWR   issuing instruction and its destination register
//   Stall            combinational: a source operand is pending
//   BusyCnt          registered count of busy registers (0..31)
module reg_file_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [ADDR_W-1:0] WR,
    input  logic [DATA_W-1:0] WD,
    input  logic              RegWrite,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] IssueWR,
    output logic              Stall,
    output logic [ADDR_W:0]   BusyCnt
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic wr_hit1;
    logic wr_hit2;
    logic pend1;
    logic pend2;
    logic issue_ok;

    // Read ports with bypass, and hazard detection against the scoreboard.
    // A write-back to the source register this cycle satisfies the operand.
    always_comb begin
        wr_hit1 = RegWrite && (WR == RA1);
        wr_hit2 = RegWrite && (WR == RA2);

        RD1 = '0;
        if (RA1 != '0) begin
            RD1 = wr_hit1 ? WD : regs[RA1];
        end
        RD2 = '0;
        if (RA2 != '0) begin
            RD2 = wr_hit2 ? WD : regs[RA2];
        end

        pend1 = (RA1 != '0) && busy[RA1] && !wr_hit1;
        pend2 = (RA2 != '0) && busy[RA2] && !wr_hit2;
        Stall = pend1 || pend2;
    end

    // Next busy vector; a new producer overrides a same-edge write-back.
    always_comb begin
        busy_nxt = '0;
        cnt_nxt  = '0;
        issue_ok = Issue && !Stall;
        for (int r = 1; r < int'(NREG); r++) begin
            busy_nxt[r] = (issue_ok && (IssueWR == ADDR_W'(r))) ||
                          (busy[r] && !(RegWrite && (WR == ADDR_W'(r))));
        end
        for (int r = 1; r < int'(NREG); r++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
        end
    end

    // Scoreboard and busy count update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            BusyCnt <= '0;
        end else begin
            busy    <= busy_nxt;
            BusyCnt <= cnt_nxt;
        end
    end

    // Register array; register 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && (WR != '0)) begin
            regs[WR] <= WD;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural register/scoreboard model.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  RA1, RA2, WR, IssueWR;
    logic [31:0] RD1, RD2, WD;
    logic        RegWrite, Issue, Stall;
    logic [5:0]  BusyCnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mregs [32];
    bit          mbusy [32];

    reg_file_sb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
        .WR(WR), .WD(WD), .RegWrite(RegWrite),
        .Issue(Issue), .IssueWR(IssueWR),
        .Stall(Stall), .BusyCnt(BusyCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWrite && WR == a) return WD;
        return mregs[a];
    endfunction

    function automatic bit exp_pend(input logic [4:0] a);
        return (a != 5'd0) && mbusy[a] && !(RegWrite && WR == a);
    endfunction

    function automatic bit exp_stall();
        return exp_pend(RA1) || exp_pend(RA2);
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 1; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'd0;
            mbusy[i] = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("RD1", RD1, exp_rd(RA1));
        chk("RD2", RD2, exp_rd(RA2));
        chk("Stall", 32'(Stall), 32'(exp_stall()));
        chk("BusyCnt", 32'(BusyCnt), 32'(exp_cnt()));
    endtask

    // Apply the architectural effect of one clock edge to the model.
    task automatic model_update();
        bit accept;
        bit wb;
        if (!rst_n) begin
            model_clear();
            return;
        end
        accept = Issue && !exp_stall() && (IssueWR != 5'd0);
        wb     = RegWrite && (WR != 5'd0);
        if (wb) begin
            mregs[WR] = WD;
            mbusy[WR] = 1'b0;
        end
        if (accept) mbusy[IssueWR] = 1'b1;
    endtask

    // Check the settled outputs, then advance one clock.
    task automatic edge_step();
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        RA1 = 5'd0; RA2 = 5'd0; WR = 5'd0; WD = 32'd0;
        RegWrite = 1'b0; Issue = 1'b0; IssueWR = 5'd0;
    endtask

    initial begin
        model_clear();
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;

        // 1. Reset
        edge_step();
        edge_step();
        rst_n = 1'b1;
        RA1 = 5'd5; RA2 = 5'd31; #2;
        chk("rst_rd1", RD1, 32'd0);
        chk("rst_rd2", RD2, 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_cnt", 32'(BusyCnt), 32'd0);
        edge_step();

        // 2. Write with bypass, then read from the array
        RegWrite = 1'b1; WR = 5'd8; WD = 32'hDEADBEEF; RA1 = 5'd8; #2;
        chk("bypass_rd1", RD1, 32'hDEADBEEF);
        edge_step();
        RegWrite = 1'b0; WD = 32'd0; #2;
        chk("array_rd1", RD1, 32'hDEADBEEF);
        edge_step();

        // 3. Register 0
        RegWrite = 1'b1; WR = 5'd0; WD = 32'h12345678; RA1 = 5'd0; #2;
        chk("r0_bypass", RD1, 32'd0);
        edge_step();
        RegWrite = 1'b0; Issue = 1'b1; IssueWR = 5'd0; #2;
        chk("r0_read", RD1, 32'd0);
        chk("r0_stall", 32'(Stall), 32'd0);
        edge_step();
        Issue = 1'b0; #2;
        chk("r0_cnt", 32'(BusyCnt), 32'd0);
        edge_step();

        // 4. Hazard, ignored issue during stall, release by write-back
        Issue = 1'b1; IssueWR = 5'd9; #2;
        edge_step();
        IssueWR = 5'd10; RA2 = 5'd9; #2;
        chk("haz_cnt1", 32'(BusyCnt), 32'd1);
        chk("haz_stall", 32'(Stall), 32'd1);
        edge_step();
        Issue = 1'b0; RegWrite = 1'b1; WR = 5'd9; WD = 32'h55; #2;
        chk("haz_cnt_nochg", 32'(BusyCnt), 32'd1);
        chk("haz_release", 32'(Stall), 32'd0);
        chk("haz_rd2", RD2, 32'h55);
        edge_step();
        idle(); #2;
        chk("haz_cnt0", 32'(BusyCnt), 32'd0);
        edge_step();

        // 5. Simultaneous set and clear
        Issue = 1'b1; IssueWR = 5'd12; #2;
        edge_step();
        RegWrite = 1'b1; WR = 5'd12; WD = 32'd7; #2;
        chk("sc_cnt_before", 32'(BusyCnt), 32'd1);
        edge_step();
        idle(); RA1 = 5'd12; #2;
        chk("sc_cnt_after", 32'(BusyCnt), 32'd1);
        chk("sc_rd1", RD1, 32'd7);
        chk("sc_stall", 32'(Stall), 32'd1);

        // Asynchronous reset between edges clears outputs at once
        rst_n = 1'b0; #1;
        model_clear();
        chk("arst_cnt", 32'(BusyCnt), 32'd0);
        chk("arst_rd1", RD1, 32'd0);
        chk("arst_stall", 32'(Stall), 32'd0);
        edge_step();
        rst_n = 1'b1; idle(); #2;
        edge_step();

        // 6. Fill all registers, saturate, then drain
        for (int r = 1; r < 32; r++) begin
            Issue = 1'b1; IssueWR = 5'(r); #2;
            chk("fill_cnt", 32'(BusyCnt), 32'(r - 1));
            edge_step();
        end
        IssueWR = 5'd5; #2;
        chk("fill_full", 32'(BusyCnt), 32'd31);
        edge_step();
        Issue = 1'b0; #2;
        chk("fill_sat", 32'(BusyCnt), 32'd31);
        for (int r = 1; r < 32; r++) begin
            RegWrite = 1'b1; WR = 5'(r); WD = 32'(r * 3); #2;
            chk("drain_cnt", 32'(BusyCnt), 32'(32 - r));
            edge_step();
        end
        idle(); #2;
        chk("drain_zero", 32'(BusyCnt), 32'd0);
        edge_step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            RA1      = 5'($urandom_range(0, 31));
            RA2      = 5'($urandom_range(0, 31));
            Issue    = 1'($urandom_range(0, 1));
            IssueWR  = 5'($urandom_range(0, 31));
            RegWrite = ($urandom_range(0, 9) < 6);
            WR       = 5'($urandom_range(0, 31));
            WD       = $urandom;
            if (($urandom_range(0, 3) == 0) && mbusy[RA1]) WR = RA1;
            #2;
            edge_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
